// File: rtl/id_stage.sv
// Instruction decode stage: captures the fetched instruction into the EX
// pipeline registers, blocks fetch while a multi-cycle MUL occupies EX,
// and stops accepting instructions for good after a HALT.
//
// Handshake: there is no valid/ready pair toward fetch. "stall" is the
// inverted ready. Whenever stall is low at a rising edge, the instruction
// presented on if_pc/if_instr is consumed at that edge. Fetch must hold
// its outputs while stall is high. ex_valid is a one-cycle pulse toward EX
// that follows each consumed instruction, and EX never back-pressures.
module id_stage #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  if_pc,
    input  logic [19:0] if_instr,
    output logic        stall,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [7:0]  ex_a,
    output logic [7:0]  ex_b,
    output logic [7:0]  ex_pc,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] retired,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MULWAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    // The counter is reloaded with MUL_CYCLES-1 on a MUL accept. With the
    // legal range of 2..15, the reload value fits in 4 bits.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] wait_cnt;

    logic [3:0] dec_op;
    logic       dec_legal;
    logic       dec_counted;

    // Opcode classification for the instruction currently offered by fetch.
    always_comb begin
        dec_op      = if_instr[19:16];
        dec_legal   = (dec_op <= OP_MUL) || (dec_op == OP_HALT);
        dec_counted = dec_legal && (dec_op != OP_NOP);
    end

    // Stall and halted are taken directly from the state register, so no
    // decode-path logic reaches these outputs.
    assign stall     = (state != ST_RUN);
    assign halted    = (state == ST_HALTED);
    assign dbg_state = state;

    // FSM, EX pipeline registers and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 4'd0;
            ex_valid <= 1'b0;
            ex_op    <= 4'h0;
            ex_a     <= 8'h00;
            ex_b     <= 8'h00;
            ex_pc    <= 8'h00;
            illegal  <= 1'b0;
            retired  <= 16'h0000;
        end else begin
            case (state)
                ST_RUN: begin
                    ex_valid <= 1'b1;
                    ex_pc    <= if_pc;
                    if (dec_legal) begin
                        ex_op   <= dec_op;
                        ex_a    <= if_instr[15:8];
                        ex_b    <= if_instr[7:0];
                        illegal <= 1'b0;
                    end else begin
                        ex_op   <= OP_NOP;
                        ex_a    <= 8'h00;
                        ex_b    <= 8'h00;
                        illegal <= 1'b1;
                    end
                    if (dec_counted && (retired != 16'hFFFF)) begin
                        retired <= retired + 16'd1;
                    end
                    if (dec_op == OP_MUL) begin
                        state    <= ST_MULWAIT;
                        wait_cnt <= MUL_LOAD;
                    end else if (dec_op == OP_HALT) begin
                        state <= ST_HALTED;
                    end
                end
                ST_MULWAIT: begin
                    ex_valid <= 1'b0;
                    illegal  <= 1'b0;
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RUN;
                    end
                end
                ST_HALTED: begin
                    ex_valid <= 1'b0;
                    illegal  <= 1'b0;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 4'd0;
                    ex_valid <= 1'b0;
                    illegal  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus a random instruction
// stream, checked against a cycle-level reference model of the stage.
module tb_id_stage;

    localparam int MC = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  if_pc;
    logic [19:0] if_instr;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [7:0]  ex_a;
    logic [7:0]  ex_b;
    logic [7:0]  ex_pc;
    logic        illegal;
    logic        halted;
    logic [15:0] retired;
    logic [1:0]  dbg_state;

    id_stage #(.MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_pc     (ex_pc),
        .illegal   (illegal),
        .halted    (halted),
        .retired   (retired),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        valid;
        logic        stall;
        logic        halted;
        logic        illegal;
        logic [15:0] retired;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  pc;
    } cyc_t;

    cyc_t        cyc_q[$];      // expected full output state after each edge
    logic [27:0] exp_q[$];      // expected {op,a,b,pc} per accepted instruction

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Behaviour per edge: reset clears everything. Otherwise the stage
    // accepts an instruction unless halted or inside a MUL window. A MUL
    // blocks the following MC-1 edges.
    logic        m_valid, m_illegal, m_halted;
    logic [15:0] m_retired;
    logic [3:0]  m_op;
    logic [7:0]  m_a, m_b, m_pc;
    int          m_wait;

    function automatic bit model_ready();
        return !m_halted && (m_wait == 0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_illegal = 0; m_halted = 0; m_retired = 0;
        m_op = 0; m_a = 0; m_b = 0; m_pc = 0; m_wait = 0;
    endtask

    // Apply inputs for the next edge, record its expected outcome, take the edge.
    task automatic step(input logic r, input logic [7:0] pc, input logic [19:0] instr);
        int opc;
        cyc_t c;
        rst      = r;
        if_pc    = pc;
        if_instr = instr;
        opc = int'(instr[19:16]);
        if (r) begin
            model_reset();
        end else if (model_ready()) begin
            m_valid = 1;
            m_pc    = pc;
            if (opc <= 6 || opc == 15) begin
                m_op = instr[19:16]; m_a = instr[15:8]; m_b = instr[7:0]; m_illegal = 0;
                if (opc != 0 && m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
            end else begin
                m_op = 0; m_a = 0; m_b = 0; m_illegal = 1;
            end
            if (opc == 6)  m_wait = MC - 1;
            if (opc == 15) m_halted = 1;
            exp_q.push_back({m_op, m_a, m_b, m_pc});
        end else begin
            m_valid = 0;
            m_illegal = 0;
            if (m_wait > 0) m_wait--;
        end
        c.valid   = m_valid;
        c.stall   = m_halted || (m_wait > 0);
        c.halted  = m_halted;
        c.illegal = m_illegal;
        c.retired = m_retired;
        c.op = m_op; c.a = m_a; c.b = m_b; c.pc = m_pc;
        cyc_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Fetch side: random junk is presented while the stage stalls, then the
    // real instruction is offered on the edge the model will accept it.
    task automatic issue(input logic [7:0] pc, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!model_ready() && guard < 40) begin
            step(1'b0, 8'($urandom), 20'($urandom));
            guard++;
        end
        if (!model_ready()) begin
            n_cmp++; n_err++;
            $display("FAIL issue_bound: model never ready for pc 0x%0h", pc);
        end else begin
            step(1'b0, pc, {op, a, b});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 20'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 20'($urandom));
    endtask

    // ---------------- monitor ----------------
    initial begin
        cyc_t c;
        logic [27:0] t;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(c.valid));
                chk("stall",    32'(stall),    32'(c.stall));
                chk("halted",   32'(halted),   32'(c.halted));
                chk("illegal",  32'(illegal),  32'(c.illegal));
                chk("retired",  32'(retired),  32'(c.retired));
                chk("ex_fields", 32'({ex_op, ex_a, ex_b, ex_pc}), 32'({c.op, c.a, c.b, c.pc}));
                if (ex_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL txn_unexpected: ex_valid with empty expected queue pc 0x%0h", ex_pc);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn", 32'({ex_op, ex_a, ex_b, ex_pc}), 32'(t));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int opc;
        model_reset();
        rst = 1'b1; if_pc = 8'h00; if_instr = 20'h0;
        do_reset(3);

        // ADD then SUB back to back, then MUL followed by pc 4
        issue(8'd0, 4'h1, 8'h12, 8'h34);
        issue(8'd1, 4'h2, 8'h12, 8'h01);
        issue(8'd2, 4'h0, 8'h77, 8'h66);
        issue(8'd3, 4'h6, 8'h05, 8'h07);
        issue(8'd4, 4'h3, 8'hF0, 8'h3C);
        // illegal opcode
        issue(8'd5, 4'h9, 8'hAA, 8'h55);
        issue(8'd6, 4'hE, 8'h11, 8'h22);
        // three consecutive MULs
        issue(8'd8, 4'h6, 8'h01, 8'h02);
        issue(8'd9, 4'h6, 8'h03, 8'h04);
        issue(8'd10, 4'h6, 8'h05, 8'h06);
        issue(8'd11, 4'h4, 8'h0F, 8'hF0);

        // reset during the first MULWAIT cycle, then resume
        issue(8'd20, 4'h6, 8'h09, 8'h09);
        do_reset(1);
        issue(8'd21, 4'h5, 8'h5A, 8'hA5);
        issue(8'd22, 4'h1, 8'h01, 8'h01);

        // random stream without HALT
        for (int i = 0; i < 150; i++) begin
            opc = $urandom_range(0, 14);
            issue(8'($urandom), 4'(opc), 8'($urandom), 8'($urandom));
        end

        // HALT then 20 idle cycles with junk on the fetch inputs
        issue(8'd7, 4'hF, 8'h00, 8'h00);
        idle(20);

        // reset leaves HALTED and accepts resume
        do_reset(2);
        issue(8'd30, 4'h1, 8'h10, 8'h20);
        issue(8'd31, 4'h6, 8'h30, 8'h40);
        issue(8'd32, 4'hF, 8'h00, 8'h00);
        idle(5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
